// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, FSM encodings
// and the ICACHE_EN-dependent cache geometry, plus PC helper functions.
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATA_W = 32;
  localparam int PC_WORD_W   = INST_ADDR_W - 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_DISCARD  = 2'd2;

`ifdef ICACHE_EN
  localparam int ICACHE_IDX_W = 6;
  localparam int ICACHE_TAG_W = PC_WORD_W - ICACHE_IDX_W;
  localparam int ICACHE_DEPTH = 64;
`endif

  // Word-align a redirect target; the two low bits are never honoured.
  function automatic logic [INST_ADDR_W-1:0] pc_align(input logic [INST_ADDR_W-1:0] addr);
    pc_align = {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [INST_ADDR_W-1:0] pc_next(input logic [INST_ADDR_W-1:0] pc);
    pc_next = pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped instruction cache, one word per line; only built with ICACHE_EN.
// Lookup is combinational on a word address, fills are written on the clock edge.
`ifdef ICACHE_EN
module icache
  import if_stage_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [PC_WORD_W-1:0]   i_lookup_addr,
  output logic                   o_hit,
  output logic [INST_DATA_W-1:0] o_word,
  input  logic                   i_fill_en,
  input  logic [PC_WORD_W-1:0]   i_fill_addr,
  input  logic [INST_DATA_W-1:0] i_fill_data
);

  logic [ICACHE_DEPTH-1:0] r_valid;
  logic [ICACHE_TAG_W-1:0] r_tag  [ICACHE_DEPTH];
  logic [INST_DATA_W-1:0]  r_data [ICACHE_DEPTH];

  logic [ICACHE_IDX_W-1:0] w_lookup_idx;
  logic [ICACHE_TAG_W-1:0] w_lookup_tag;
  logic [ICACHE_IDX_W-1:0] w_fill_idx;

  assign w_lookup_idx = i_lookup_addr[ICACHE_IDX_W-1:0];
  assign w_lookup_tag = i_lookup_addr[PC_WORD_W-1:ICACHE_IDX_W];
  assign w_fill_idx   = i_fill_addr[ICACHE_IDX_W-1:0];

  // Only the valid bits need clearing; tag/data are qualified by them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= {ICACHE_DEPTH{1'b0}};
    end else if (i_fill_en) begin
      r_valid[w_fill_idx] <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_tag[w_fill_idx]  <= i_fill_addr[PC_WORD_W-1:ICACHE_IDX_W];
      r_data[w_fill_idx] <= i_fill_data;
    end
  end

  assign o_hit  = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);
  assign o_word = r_data[w_lookup_idx];

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, one-entry output slot and memory
// request FSM (IDLE/WAIT_MEM/DISCARD). Optional cache enabled by ICACHE_EN.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   stall_in,
  input  logic                   jump_flag,
  input  logic [INST_ADDR_W-1:0] jump_target,
  output logic                   fetch_req,
  output logic [INST_ADDR_W-1:0] fetch_addr,
  input  logic                   fetch_done,
  input  logic [INST_DATA_W-1:0] fetch_data,
  output logic [INST_ADDR_W-1:0] pc_out,
  output logic [INST_DATA_W-1:0] instr_out,
  output logic                   instr_valid
);

  logic [1:0]             r_state;
  logic [INST_ADDR_W-1:0] r_pc;
  logic                   r_fetch_req;
  logic [INST_ADDR_W-1:0] r_fetch_addr;
  logic [INST_ADDR_W-1:0] r_pc_out;
  logic [INST_DATA_W-1:0] r_instr_out;
  logic                   r_instr_valid;

  logic                   w_slot_free;
  logic                   w_hit;
  logic [INST_DATA_W-1:0] w_hit_word;

  // Slot can take a new word when empty or drained this edge (rdy_in gated in the FSM).
  assign w_slot_free = !r_instr_valid || !stall_in;

`ifdef ICACHE_EN
  logic w_fill_en;

  assign w_fill_en = rst_in && rdy_in && fetch_done && (r_state != ST_IDLE);

  icache u_icache (
    .i_clk         (clk_in),
    .i_rst_n       (rst_in),
    .i_lookup_addr (r_pc[INST_ADDR_W-1:2]),
    .o_hit         (w_hit),
    .o_word        (w_hit_word),
    .i_fill_en     (w_fill_en),
    .i_fill_addr   (r_fetch_addr[INST_ADDR_W-1:2]),
    .i_fill_data   (fetch_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = {INST_DATA_W{1'b0}};
`endif

  // Fetch FSM; a redirect wins over everything except reset and a low rdy_in.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state       <= ST_IDLE;
      r_pc          <= {INST_ADDR_W{1'b0}};
      r_fetch_req   <= 1'b0;
      r_fetch_addr  <= {INST_ADDR_W{1'b0}};
      r_pc_out      <= {INST_ADDR_W{1'b0}};
      r_instr_out   <= {INST_DATA_W{1'b0}};
      r_instr_valid <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (jump_flag) begin
            r_pc          <= pc_align(jump_target);
            r_instr_valid <= 1'b0;
          end else if (w_slot_free) begin
            if (w_hit) begin
              r_pc_out      <= r_pc;
              r_instr_out   <= w_hit_word;
              r_instr_valid <= 1'b1;
              r_pc          <= pc_next(r_pc);
            end else begin
              r_fetch_req   <= 1'b1;
              r_fetch_addr  <= r_pc;
              r_instr_valid <= 1'b0;
              r_state       <= ST_WAIT_MEM;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (fetch_done) begin
            r_fetch_req <= 1'b0;
            r_state     <= ST_IDLE;
            if (jump_flag) begin
              r_pc          <= pc_align(jump_target);
              r_instr_valid <= 1'b0;
            end else begin
              r_pc_out      <= r_fetch_addr;
              r_instr_out   <= fetch_data;
              r_instr_valid <= 1'b1;
              r_pc          <= pc_next(r_fetch_addr);
            end
          end else if (jump_flag) begin
            // The memory cannot abort, so keep requesting and drop the reply later.
            r_pc          <= pc_align(jump_target);
            r_instr_valid <= 1'b0;
            r_state       <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (fetch_done) begin
            r_fetch_req <= 1'b0;
            r_state     <= ST_IDLE;
          end
          if (jump_flag) begin
            r_pc <= pc_align(jump_target);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_fetch_req   <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req   = r_fetch_req;
  assign fetch_addr  = r_fetch_addr;
  assign pc_out      = r_pc_out;
  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations follow ICACHE_EN
// where the cache changes observable timing.
module tb_if_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_data;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  if_stage dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .stall_in    (stall_in),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_data  (fetch_data),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .instr_valid (instr_valid)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk_in);
  endtask

  // Memory reply: word at addr is addr + 0x13.
  task automatic complete_fetch(input logic [31:0] addr, input int waits);
    for (int i = 0; i < waits; i++) begin
      n_checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== addr) begin
        n_fail++;
        $display("FAIL hold_req: fetch_req=%b fetch_addr=%h, required 1 / %h", fetch_req, fetch_addr, addr);
      end
      tick();
    end
    fetch_done = 1'b1;
    fetch_data = addr + 32'h13;
    tick();
    fetch_done = 1'b0;
    fetch_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; stall_in = 1'b0; jump_flag = 1'b0;
    jump_target = 32'h0; fetch_done = 1'b0; fetch_data = 32'h0;
    tick();
    rdy_in = 1'b0;
    tick();
    rdy_in = 1'b1;
    n_checks++;
    if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", fetch_req); end
    n_checks++;
    if (fetch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", fetch_addr); end
    n_checks++;
    if (pc_out !== 32'h0 || instr_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_slot: pc_out=%h instr_out=%h, required 0/0", pc_out, instr_out);
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
  endtask

  task automatic test_first_fetch();
    rst_in = 1'b1;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h valid=%b, required 1/0/0", fetch_req, fetch_addr, instr_valid);
    end
    stall_in = 1'b1;
    complete_fetch(32'h0, 2);
    n_checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h00000013 || fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL first_deliver: valid=%b pc=%h instr=%h req=%b, required 1/0/00000013/0",
               instr_valid, pc_out, instr_out, fetch_req);
    end
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h13 || fetch_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b, required 1/0/13/0",
                 i, instr_valid, pc_out, instr_out, fetch_req);
      end
    end
  endtask

  task automatic test_rdy_and_release();
    rdy_in = 1'b0; stall_in = 1'b0; jump_flag = 1'b1; jump_target = 32'h40;
    tick();
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h13 || fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_freeze: valid=%b pc=%h instr=%h req=%b, required 1/0/13/0",
               instr_valid, pc_out, instr_out, fetch_req);
    end
    rdy_in = 1'b1; jump_flag = 1'b0;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h4 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: req=%b addr=%h valid=%b, required 1/4/0", fetch_req, fetch_addr, instr_valid);
    end
  endtask

  task automatic test_jump_wait();
    stall_in = 1'b1;
    complete_fetch(32'h4, 1);
    n_checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'h17) begin
      n_fail++; $display("FAIL second_deliver: valid=%b pc=%h instr=%h, required 1/4/17", instr_valid, pc_out, instr_out);
    end
    stall_in = 1'b0;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h8) begin
      n_fail++; $display("FAIL req_8: req=%b addr=%h, required 1/8", fetch_req, fetch_addr);
    end
    jump_flag = 1'b1; jump_target = 32'h100;
    tick();
    jump_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== 32'h8 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL discard_hold[%0d]: req=%b addr=%h valid=%b, required 1/8/0", i, fetch_req, fetch_addr, instr_valid);
      end
      if (i < 2) tick();
    end
    fetch_done = 1'b1; fetch_data = 32'hBAD00008;
    tick();
    fetch_done = 1'b0; fetch_data = 32'h0;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL discard_drop: valid=%b req=%b, required 0/0", instr_valid, fetch_req);
    end
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h100 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL jump_req: req=%b addr=%h valid=%b, required 1/100/0", fetch_req, fetch_addr, instr_valid);
    end
  endtask

  task automatic test_jump_done();
    fetch_done = 1'b1; fetch_data = 32'h113; jump_flag = 1'b1; jump_target = 32'h103;
    tick();
    fetch_done = 1'b0; fetch_data = 32'h0; jump_flag = 1'b0; stall_in = 1'b1;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL coincide_drop: valid=%b req=%b, required 0/0", instr_valid, fetch_req);
    end
    tick();
`ifdef ICACHE_EN
    n_checks++;
    if (fetch_req !== 1'b0 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL coincide_hit: req=%b valid=%b, required 0/1", fetch_req, instr_valid);
    end
`else
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h100 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL coincide_req: req=%b addr=%h valid=%b, required 1/100/0", fetch_req, fetch_addr, instr_valid);
    end
    complete_fetch(32'h100, 1);
`endif
    n_checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h113) begin
      n_fail++; $display("FAIL deliver_100: valid=%b pc=%h instr=%h, required 1/100/113", instr_valid, pc_out, instr_out);
    end
  endtask

  task automatic test_reset_mid();
    stall_in = 1'b0; jump_flag = 1'b1; jump_target = 32'h300;
    tick();
    jump_flag = 1'b0;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h300) begin
      n_fail++; $display("FAIL req_300: req=%b addr=%h, required 1/300", fetch_req, fetch_addr);
    end
    tick();
    rst_in = 1'b0;
    tick();
    n_checks++;
    if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || fetch_addr !== 32'h0 || pc_out !== 32'h0 || instr_out !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset: req=%b valid=%b addr=%h pc=%h instr=%h, required all 0",
               fetch_req, instr_valid, fetch_addr, pc_out, instr_out);
    end
    rst_in = 1'b1;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_req: req=%b addr=%h valid=%b, required 1/0/0", fetch_req, fetch_addr, instr_valid);
    end
  endtask

  task automatic test_pc_wrap();
    stall_in = 1'b1;
    complete_fetch(32'h0, 1);
    stall_in = 1'b0; jump_flag = 1'b1; jump_target = 32'hFFFFFFFC;
    tick();
    jump_flag = 1'b0;
    tick();
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'hFFFFFFFC) begin
      n_fail++; $display("FAIL req_top: req=%b addr=%h, required 1/fffffffc", fetch_req, fetch_addr);
    end
    stall_in = 1'b1;
    complete_fetch(32'hFFFFFFFC, 1);
    n_checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'hFFFFFFFC || instr_out !== 32'h0000000F) begin
      n_fail++; $display("FAIL deliver_top: valid=%b pc=%h instr=%h, required 1/fffffffc/0000000f", instr_valid, pc_out, instr_out);
    end
    stall_in = 1'b0;
    tick();
`ifdef ICACHE_EN
    n_checks++;
    if (fetch_req !== 1'b0 || instr_valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h13) begin
      n_fail++; $display("FAIL wrap_hit: req=%b valid=%b pc=%h instr=%h, required 0/1/0/13", fetch_req, instr_valid, pc_out, instr_out);
    end
`else
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_req: req=%b addr=%h valid=%b, required 1/0/0", fetch_req, fetch_addr, instr_valid);
    end
`endif
  endtask

  // One pass over 0x0..0xC with a 1-cycle memory; redirects back to 0 on the last word.
  task automatic run_pass(output int fetches, output int cycles);
    logic [31:0] exp_pc;
    jump_flag = 1'b1; jump_target = 32'h0;
    tick();
    jump_flag = 1'b0;
    exp_pc = 32'h0; fetches = 0; cycles = 0;
    while (exp_pc != 32'h10 && cycles < 60) begin
      cycles++;
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (pc_out !== exp_pc || instr_out !== exp_pc + 32'h13) begin
          n_fail++; $display("FAIL loop_word: pc=%h instr=%h, required %h/%h", pc_out, instr_out, exp_pc, exp_pc + 32'h13);
        end
        exp_pc = exp_pc + 32'h4;
      end
      if (fetch_req === 1'b1 && fetch_done === 1'b0) begin
        fetch_done = 1'b1; fetch_data = fetch_addr + 32'h13; fetches++;
      end else begin
        fetch_done = 1'b0;
      end
      if (exp_pc == 32'h10) jump_flag = 1'b1;
      tick();
    end
    jump_flag = 1'b0; fetch_done = 1'b0; fetch_data = 32'h0;
    n_checks++;
    if (exp_pc != 32'h10) begin
      n_fail++; $display("FAIL loop_timeout: reached pc %h, required 00000010", exp_pc);
    end
  endtask

  task automatic test_loop();
    int f1, c1, f2, c2;
    int exp_f2, exp_c2;
    stall_in = 1'b0; rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    run_pass(f1, c1);
    run_pass(f2, c2);
`ifdef ICACHE_EN
    exp_f2 = 0; exp_c2 = 5;
`else
    exp_f2 = 4; exp_c2 = 9;
`endif
    n_checks++;
    if (f1 != 4 || c1 != 9) begin
      n_fail++; $display("FAIL loop_pass1: fetches=%0d cycles=%0d, required 4/9", f1, c1);
    end
    n_checks++;
    if (f2 != exp_f2 || c2 != exp_c2) begin
      n_fail++; $display("FAIL loop_pass2: fetches=%0d cycles=%0d, required %0d/%0d", f2, c2, exp_f2, exp_c2);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_rdy_and_release();
    test_jump_wait();
    test_jump_done();
    test_reset_mid();
    test_pc_wrap();
    test_loop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk_in  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: rst_in  input  1  synchronous reset, active-low (0 = reset), sampled on clk_in rising edge.
REQ-003 SHALL have: rdy_in  input  1  global ready; 0 freezes all state and outputs.
REQ-004 SHALL have: stall_in  input  1  downstream IF/ID stall; 1 = slot not consumed this cycle.
REQ-005 SHALL have: jump_flag  input  1  redirect request from EX; jump_target  input  32  redirect PC.
REQ-006 SHALL have: fetch_req  output  1  memory request, held until fetch_done; fetch_addr  output  32  word address of request.
REQ-007 SHALL have: fetch_done  input  1  one-cycle completion pulse; fetch_data  input  32  instruction word, valid with fetch_done.
REQ-008 SHALL have: pc_out  output  32  PC of delivered instruction; instr_out  output  32  instruction word; instr_valid  output  1  output slot full.

Function
REQ-009 Output slot SHALL be consumed on an edge where instr_valid=1, stall_in=0, rdy_in=1; pc_out/instr_out SHALL stay stable while valid and not consumed.
REQ-010 FSM states SHALL be IDLE, WAIT_MEM, DISCARD.
REQ-011 IDLE, slot empty or consumed this edge, no jump: on cache hit at pc, load slot {pc, hit word}, pc <= pc+4, stay IDLE (1-cycle latency, back-to-back delivery).
REQ-012 IDLE, same conditions, miss: assert fetch_req, fetch_addr=pc, go WAIT_MEM; slot becomes empty if consumed.
REQ-013 IDLE with slot full and not consumed: no request, no PC change.
REQ-014 WAIT_MEM: fetch_req=1, fetch_addr constant; on fetch_done load slot {pc, fetch_data}, fill cache, pc <= pc+4, fetch_req <= 0, go IDLE.
REQ-015 jump_flag=1 SHALL have top priority: pc <= jump_target, instr_valid <= 0 same edge, regardless of stall_in.
REQ-016 jump in WAIT_MEM without fetch_done: go DISCARD; fetch_req stays high until fetch_done (no abort).
REQ-017 DISCARD: on fetch_done, fill cache at old fetch_addr, do not load slot, go IDLE; jump in DISCARD updates pc only.
REQ-018 jump coincident with fetch_done in WAIT_MEM: drop data from slot, fill cache, pc <= jump_target, go IDLE.
REQ-019 PC arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0; pc[1:0] always 00 (jump_target[1:0] ignored).
REQ-020 rdy_in=0 SHALL override stall_in and jump_flag (no effect that cycle); fetch_done while rdy_in=0 SHALL NOT occur.

Reset
REQ-021 rst_in=0 at an edge SHALL set pc=0, state IDLE, fetch_req=0, fetch_addr=0, pc_out=0, instr_out=0, instr_valid=0, all cache valid bits 0; overrides rdy_in.
REQ-022 Reset mid-WAIT_MEM SHALL drop the request; memory controller SHALL be reset by the same rst_in.

Configuration
REQ-023 Macro ICACHE_EN defined: 64-entry direct-mapped cache, one word per line, index pc[7:2], tag pc[31:8], valid bit per line.
REQ-024 ICACHE_EN undefined: no cache storage, hit tied 0, every instruction goes through WAIT_MEM (min 2-cycle delivery latency).

Structure
REQ-025 State encodings, ICACHE_EN-dependent index/tag widths, InstAddrBus/InstDataBus widths SHALL live in the shared define.v header.
REQ-026 Cache SHALL be sub-module icache (lookup addr -> hit, word combinational; fill port write-on-edge), instantiated only under ICACHE_EN.

Verification
REQ-027 Reset then release, memory returns 0x00000013 at 0x0 after 3 cycles -> fetch_addr=0x0, instr_valid=1 with pc_out=0x0, instr_out=0x00000013, next fetch_addr=0x4.
REQ-028 stall_in=1 for 5 cycles while valid -> pc_out/instr_out unchanged, fetch_req=0 throughout, next fetch issued on the edge stall drops.
REQ-029 jump_flag with jump_target=0x100 while in WAIT_MEM for 0x8 -> instr_valid=0, fetch_req held until done, 0x8 data never valid, next fetch_addr=0x100.
REQ-030 jump_target=0x103 coincident with fetch_done -> data dropped, next fetch_addr=0x100.
REQ-031 ICACHE_EN: loop 0x0..0xC executed twice -> second pass no fetch_req, one instruction per cycle; without ICACHE_EN every pass issues 4 fetches.
REQ-032 rst_in=0 asserted during WAIT_MEM -> next cycle fetch_req=0, instr_valid=0, pc restarts at 0x0, cache empty.
